// File: rtl/bitslam_pkg.sv
// bitslam_pkg: shared constants, widths and FSM state type for the bitslam write path
//   ADDR_*   : synth register addresses
//   ADDR_W/DATA_W : bus field widths
//   state_t  : sequencer FSM states; wr_t : one queued register write
package bitslam_pkg;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 6;
   localparam logic [ADDR_W-1:0] ADDR_V0_DIV = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_V0_TAP = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_V1_DIV = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_V1_TAP = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_MIX    = 3'd4;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;
endpackage

// File: rtl/bitslam_write_seq_if.sv
// bitslam_write_seq_if: request handshake plus synth bus and status signals
//   master : requester side (drives req_*, observes bus/status)
//   slave  : sequencer side (accepts req_*, drives bus/status)
interface bitslam_write_seq_if import bitslam_pkg::*; #(parameter int DEPTH = 4);
   logic                    req_valid;
   logic                    req_ready;
   logic [ADDR_W-1:0]       req_addr;
   logic [DATA_W-1:0]       req_data;
   logic                    bus_sel;
   logic [DATA_W-1:0]       bus_addr_data;
   logic                    busy;
   logic [$clog2(DEPTH):0]  fifo_level;
   modport master (output req_valid, req_addr, req_data,
                   input  req_ready, bus_sel, bus_addr_data, busy, fifo_level);
   modport slave  (input  req_valid, req_addr, req_data,
                   output req_ready, bus_sel, bus_addr_data, busy, fifo_level);
endinterface

// File: rtl/bitslam_fifo.sv
// bitslam_fifo: synchronous FIFO with combinational head
//   i_push/i_din : write (ignored when full)   i_pop : read (ignored when empty)
//   o_head : oldest entry   o_full/o_empty/o_level : occupancy status
module bitslam_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_din,
   output logic [W-1:0]             o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_level;
   logic          w_push, w_pop;
   assign o_full  = r_level == (AW+1)'(DEPTH);
   assign o_empty = r_level == '0;
   assign o_level = r_level;
   assign o_head  = r_mem[r_rp];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_din;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end
endmodule

// File: rtl/bitslam_write_seq.sv
// bitslam_write_seq: queues register writes and serialises them onto the synth's two-phase bus
//   clk/rst : clock, synchronous active-high reset
//   io      : req_valid/req_ready/req_addr/req_data in, bus_sel/bus_addr_data/busy/fifo_level out
module bitslam_write_seq import bitslam_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   bitslam_write_seq_if.slave   io
);
   wr_t               w_head;
   logic              w_full, w_empty, w_pop, w_hit;
   state_t            r_state;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_sel;
   logic [DATA_W-1:0] r_bus;
   bitslam_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (io.req_valid & io.req_ready),
      .i_pop   (w_pop),
      .i_din   ({io.req_addr, io.req_data}),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (io.fifo_level)
   );
   // ADDR always proceeds to its own DATA, so only IDLE/DATA may take the next entry
   assign w_pop            = (r_state != ADDR) & ~w_empty;
   assign w_hit            = w_head.addr == r_cur_addr;
   assign io.req_ready     = ~w_full;
   assign io.busy          = (r_state != IDLE) | ~w_empty;
   assign io.bus_sel       = r_sel;
   assign io.bus_addr_data = r_bus;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cur_addr <= '0;
         r_data     <= '0;
         r_sel      <= 1'b0;
         r_bus      <= '0;
      end else if (w_pop) begin
         r_data  <= w_head.data;
         r_state <= w_hit ? DATA : ADDR;
         r_sel   <= w_hit;
         r_bus   <= w_hit ? w_head.data : {3'b000, w_head.addr};
         if (!w_hit) r_cur_addr <= w_head.addr;
      end else if (r_state == ADDR) begin
         r_state <= DATA;
         r_sel   <= 1'b1;
         r_bus   <= r_data;
      end else begin
         // idle drive re-latches the synth's current address, which is harmless
         r_state <= IDLE;
         r_sel   <= 1'b0;
         r_bus   <= {3'b000, r_cur_addr};
      end
   end
endmodule
